// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the MEM-stage data memory
//               responder and its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Responder transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Byte offset of the word index inside a byte address (32-bit words).
  localparam int WORD_OFFSET = 2;

  // Width of a word index into an array of the given depth.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : Single-port synchronous RAM of DEPTH words of N bits.
//               Registered read every cycle, write when WE is high.
//               Contents are not affected by any reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array
  import mem_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 64
) (
  input  logic                          CLK,
  input  logic                          WE,
  input  logic [idx_width(DEPTH)-1:0]   Idx,
  input  logic [N-1:0]                  WD,
  output logic [N-1:0]                  RD
);

  logic [N-1:0] r_mem [DEPTH];

  // Write on WE and read the addressed word into RD on every rising edge.
  always_ff @(posedge CLK) begin
    if (WE) begin
      r_mem[Idx] <= WD;
    end
    RD <= r_mem[Idx];
  end

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : MEM-stage data memory responder. Accepts one load or store
//               per transaction, inserts WAIT wait states, acknowledges with
//               a one-cycle Ack_o and holds the pipeline via Stall_o.
//               Optional misaligned-access check: DATA_MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
// The parameter WAIT shares its name with the WAIT state literal, so the
// package items are imported by name and state literals are package-scoped.
module data_mem_responder
  import mem_pkg::mem_state_t, mem_pkg::idx_width, mem_pkg::WORD_OFFSET;
#(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Req_i,
  input  logic          MemWE_i,
  input  logic [N-1:0]  Addr_i,
  input  logic [N-1:0]  WData_i,
  output logic [N-1:0]  ReadData_o,
  output logic          Ack_o,
  output logic          Stall_o,
  output logic          Err_o
);

  localparam int         c_IDX_W = idx_width(DEPTH);
  localparam logic [3:0] c_WAIT  = 4'(WAIT);

  mem_state_t           r_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic                 r_misaligned;
  logic                 r_bubble;
  logic                 r_load_resp;
  logic                 r_ack;
  logic                 r_err;
  logic [c_IDX_W-1:0]   r_idx;
  logic [N-1:0]         r_wdata;
  logic [N-1:0]         r_read_data;

  logic [c_IDX_W-1:0]   w_idx;
  logic [c_IDX_W-1:0]   w_ram_idx;
  logic                 w_accept;
  logic                 w_misaligned;
  logic                 w_ram_we;
  logic [N-1:0]         w_ram_rd;
  logic [N-1:0]         w_load_value;
  logic                 w_unused_bits;

  // Word index; upper address bits wrap the access modulo DEPTH words.
  assign w_idx = Addr_i[WORD_OFFSET +: c_IDX_W];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_misaligned  = (Addr_i[WORD_OFFSET-1:0] != '0);
  assign Err_o         = r_err;
  assign w_unused_bits = ^Addr_i[N-1:WORD_OFFSET+c_IDX_W];
`else
  assign w_misaligned  = 1'b0;
  assign Err_o         = 1'b0;
  assign w_unused_bits = ^{Addr_i[N-1:WORD_OFFSET+c_IDX_W],
                           Addr_i[WORD_OFFSET-1:0], r_err};
`endif

  // The first IDLE cycle after RESP is a bubble in which no request is taken.
  assign w_accept = (r_state == mem_pkg::IDLE) && Req_i && !r_bubble;

  // In IDLE the array looks at the live address so a zero-wait load can be
  // read in its acceptance cycle; afterwards the latched index is used.
  assign w_ram_idx = (r_state == mem_pkg::IDLE) ? w_idx : r_idx;

  // Stores commit on the edge that ends RESP, unless flagged misaligned.
  assign w_ram_we = (r_state == mem_pkg::RESP) && r_we && !r_misaligned;

  // A misaligned load returns zero instead of array data.
  assign w_load_value = r_misaligned ? '0 : w_ram_rd;

  // Hold the pipe while a request waits in IDLE or the access is in WAIT.
  assign Stall_o = ((r_state == mem_pkg::IDLE) && Req_i) ||
                   (r_state == mem_pkg::WAIT);

  // During a load's RESP the freshly read word is presented; otherwise the
  // last completed load value is held.
  assign ReadData_o = r_load_resp ? w_load_value : r_read_data;
  assign Ack_o      = r_ack;

  data_mem_array #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_array (
    .CLK (CLK),
    .WE  (w_ram_we),
    .Idx (w_ram_idx),
    .WD  (r_wdata),
    .RD  (w_ram_rd)
  );

  // Transaction FSM: latch the request, count wait states, pulse Ack in RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= mem_pkg::IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_misaligned <= 1'b0;
      r_bubble     <= 1'b0;
      r_load_resp  <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_read_data  <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        mem_pkg::IDLE: begin
          r_bubble <= 1'b0;
          if (w_accept) begin
            r_we         <= MemWE_i;
            r_idx        <= w_idx;
            r_wdata      <= WData_i;
            r_misaligned <= w_misaligned;
            r_cnt        <= c_WAIT;
            if (c_WAIT == 4'd0) begin
              r_state     <= mem_pkg::RESP;
              r_ack       <= 1'b1;
              r_err       <= w_misaligned;
              r_load_resp <= !MemWE_i;
            end else begin
              r_state <= mem_pkg::WAIT;
            end
          end
        end
        mem_pkg::WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= mem_pkg::RESP;
            r_ack       <= 1'b1;
            r_err       <= r_misaligned;
            r_load_resp <= !r_we;
          end
        end
        mem_pkg::RESP: begin
          r_state     <= mem_pkg::IDLE;
          r_bubble    <= 1'b1;
          r_load_resp <= 1'b0;
          if (r_load_resp) begin
            r_read_data <= w_load_value;
          end
        end
        default: begin
          r_state <= mem_pkg::IDLE;
        end
      endcase
    end
  end

endmodule : data_mem_responder
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the MEM stage of the 5-stage pipeline. It accepts one load or store request per transaction from the EX/MEM pipe outputs, inserts a fixed number of wait states, and returns read data toward the MEM/WB pipe `ReadData_i`. While a transaction is in flight it holds `Stall_o` so the pipe registers freeze.

## Interface
- `N`, 32, data and address width.
- `DEPTH`, 64, number of N-bit words in the array; power of two, 16..1024.
- `WAIT`, 2, wait states per access; 0..15.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `Req_i`  in  1  request valid, from the EX/MEM stage.
- `MemWE_i`  in  1  1 = store, 0 = load; from `MemWE_o` of EX/MEM.
- `Addr_i`  in  N  byte address; from `AluResult_o` of EX/MEM.
- `WData_i`  in  N  store data; from `RD2_o` of EX/MEM.
- `ReadData_o`  out  N  load data, registered.
- `Ack_o`  out  1  one-cycle completion pulse.
- `Stall_o`  out  1  pipeline hold, combinational.
- `Err_o`  out  1  misaligned-access flag; see Configuration.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If `Req_i`=1, latch `MemWE_i`, the word index and `WData_i`, and load the wait counter with `WAIT`.
  - Next state is WAIT if `WAIT`>0, otherwise RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP on the cycle the counter reaches 1.
- **RESP**
  - `Ack_o`=1 for exactly this cycle.
  - Next state is always IDLE.
  - `Req_i` is ignored in RESP because it still carries the finishing request.
- **Word index:** `Addr_i[2 +: log2(DEPTH)]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words. `Addr_i[1:0]` is ignored unless the alignment check is enabled.
- **Load:**
  - The array is read during the last pre-RESP cycle.
  - `ReadData_o` is valid in the RESP cycle and holds its value until the next load completes.
- **Store:**
  - The array is written on the edge that ends RESP.
  - `ReadData_o` is unchanged by a store.
- `Req_i`, `MemWE_i`, `Addr_i` and `WData_i` must stay stable from acceptance through RESP. This is guaranteed by `Stall_o`; the block uses only the latched copies.
- `Stall_o` = (IDLE && `Req_i`) || WAIT.
- **Back-to-back requests:** the next request is accepted in IDLE one cycle after RESP. One bubble cycle between transactions is required behaviour.
- **Reset:**
  - Asynchronous return to IDLE; the counter clears.
  - `ReadData_o`=0, `Ack_o`=0, `Err_o`=0, `Stall_o` follows its combinational equation.
  - A pending store is discarded and never written.
  - Array contents are not cleared by reset.

## Timing
- Request first seen in IDLE in cycle 0.
- Transaction latency: `Stall_o`=1 in cycles 0..WAIT, and `Ack_o`=1 in cycle WAIT+1. A request accepted in cycle 0 therefore holds the pipeline for WAIT+1 cycles.
- With `WAIT`=0: one stall cycle, `Ack_o` in cycle 1.
- Throughput: one transaction per WAIT+3 cycles when requests are continuous.
- Store data is visible to a load accepted in any later cycle.

## Configuration
- Macro: `DATA_MEM_ALIGN_CHECK_EN`.
- **Defined:**
  - If `Addr_i[1:0]`≠0 at acceptance, the transaction still runs the full WAIT/RESP sequence.
  - In RESP, `Err_o`=1 together with `Ack_o`.
  - The store is suppressed, and a load returns `ReadData_o`=0.
- **Undefined:** `Err_o` is tied to 0 and the low address bits are ignored.

## Structure
- **Shared package `mem_pkg`:**
  - enum `mem_state_t` {IDLE, WAIT, RESP};
  - localparam `WORD_OFFSET`=2;
  - function `clog2`-based index width.
- **Sub-module `data_mem_array`:**
  - single-port synchronous RAM, parameters N and DEPTH;
  - ports `CLK`, `WE`, `Idx`, `WD`, `RD`;
  - no reset.
- The FSM, counter and latches stay in `data_mem_responder`.

## Test plan
- **Reset values:** assert `RST` mid-cycle → all outputs 0 immediately, state IDLE.
- **Store then load, WAIT=2:**
  - store 0xDEADBEEF to 0x10 → `Stall_o`=1 in cycles 0–2, `Ack_o` in cycle 3;
  - load from 0x10 → `ReadData_o`=0xDEADBEEF with `Ack_o`.
- **WAIT=0:** load from an unwritten-after-store address 0x10 → one stall cycle, `Ack_o` in cycle 1, then the next request is accepted in cycle 3.
- **Wrap-around, DEPTH=64:** store 0x12345678 to 0x100, load from 0x000 → returns 0x12345678.
- **Reset mid-WAIT of a store:** store 0xCAFEF00D to 0x20 and pulse `RST` in cycle 1 → no `Ack_o`; a later load from 0x20 returns the old value.
- **With `DATA_MEM_ALIGN_CHECK_EN`:** store to 0x13 → `Err_o`=`Ack_o`=1 in RESP, and memory at 0x10 is unchanged.
